// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and iteration count shared by the
// multiply/divide unit and its bench.
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int ITER = 32;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-divide step; shifted partial remainder and
// divisor in, next remainder and quotient bit out.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] diff;
    // rem_i < 2*d, so a set top bit of the difference means a borrow
    assign diff  = rem_i - {1'b0, d_i};
    assign q_o   = ~diff[WIDTH];
    assign rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MULT/MULTU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITER);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dvz_q, dvz_d, done_q, done_d;
    logic [WIDTH-1:0] a_q, a_d, opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic a_neg, b_neg, q_bit;
    logic [WIDTH-1:0] mag_a, mag_b, rem_nx, quo, rem;
    logic [WIDTH:0] sum;

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // acc holds {partial, multiplier} for multiply, {remainder, dividend/quotient} for divide
    muldiv_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i({acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}),
        .d_i  (opnd_q),
        .rem_o(rem_nx),
        .q_o  (q_bit)
    );

    assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dvz_d    = dvz_q;
        a_d      = a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                hi_d = hi_we ? wd : hi_q;
                lo_d = lo_we ? wd : lo_q;
                if (start) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dvz_d    = (b == '0);
                    a_d      = a;
                    opnd_d   = op[1] ? mag_b : mag_a;
                    acc_d    = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
`ifdef MULDIV_FAST_MUL_EN
                    if (!op[1]) begin
                        state_d = FIX;
                        acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                    end
`endif
                end
            end
            CALC: begin
                cnt_d   = cnt_q + 1'b1;
                acc_d   = is_div_q ? {rem_nx, acc_q[WIDTH-2:0], q_bit} : {sum, acc_q[WIDTH-1:1]};
                state_d = (cnt_q == CW'(ITER - 1)) ? FIX : CALC;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = !is_div_q ? prod[2*WIDTH-1:WIDTH] : dvz_q ? a_q : rem;
                lo_d    = !is_div_q ? prod[WIDTH-1:0] : dvz_q ? '1 : quo;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dvz_q    <= 1'b0;
            done_q   <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dvz_q    <= dvz_d;
            done_q   <= done_d;
            a_q      <= a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an
// arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk, rst, start, hi_we, lo_we;
    logic [1:0] op;
    logic [31:0] a, b, wd;
    logic busy, done;
    logic [31:0] hi, lo;
    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // returns {HI, LO} computed with plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] ux, uy, p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (!o[1]) p = o[0] ? ux * uy : 64'(sx * sy);
        else if (y == 32'b0) p = {x, 32'hFFFFFFFF};
        else if (o[0]) p = {32'(ux % uy), 32'(ux / uy)};
        else p = {32'(sx % sy), 32'(sx / sy)};
        return p;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inj, input logic wr);
        logic [63:0] r;
        int n, lat;
        r = model(o, x, y);
        lat = 33;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[1]) lat = 1;
`endif
        op = o; a = x; b = y; start = 1'b1;
        if (wr) begin hi_we = 1'b1; lo_we = 1'b1; wd = 32'h5A5A5A5A; end
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        check("accept_busy", busy, 1);
        check("accept_done", done, 0);
        if (wr && lat > 1) begin
            check("mt_with_start_hi", hi, 32'h5A5A5A5A);
            check("mt_with_start_lo", lo, 32'h5A5A5A5A);
        end
        n = 0;
        while (!done && n < 100) begin
            if (n == inj) begin
                start = 1'b1; op = OP_MULTU; a = 2; b = 2;
                hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD;
            end
            tick();
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            n++;
        end
        check("latency", n, lat);
        check("result_hi", hi, r[63:32]);
        check("result_lo", lo, r[31:0]);
        check("done_busy", busy, 0);
    endtask

    initial begin
        logic [1:0] rop;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = 32'b0; b = 32'b0; wd = 32'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        hi_we = 1'b1; wd = 32'hAAAA; tick(); hi_we = 1'b0;
        check("mthi_hi", hi, 32'hAAAA);
        check("mthi_lo", lo, 0);
        lo_we = 1'b1; wd = 32'hBBBB; tick(); lo_we = 1'b0;
        check("mtlo_hi", hi, 32'hAAAA);
        check("mtlo_lo", lo, 32'hBBBB);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCCCC; tick(); hi_we = 1'b0; lo_we = 1'b0;
        check("mtboth_hi", hi, 32'hCCCC);
        check("mtboth_lo", lo, 32'hCCCC);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
        check("multu_max_hi", hi, 32'hFFFFFFFE);
        check("multu_max_lo", lo, 32'h00000001);
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, -1, 1'b0);
        check("mult_neg_lo", lo, 32'hFFFFFFF1);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
        check("div_neg_lo", lo, 32'hFFFFFFFD);
        check("div_neg_hi", hi, 32'hFFFFFFFF);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
        check("div_ovf_lo", lo, 32'h80000000);
        run_op(OP_DIVU, 32'h123, 32'h0, -1, 1'b0);
        check("divu_zero_hi", hi, 32'h123);
        run_op(OP_DIV, 32'hFFFFFF00, 32'h0, -1, 1'b0);

        run_op(OP_DIVU, 32'd100, 32'd7, 10, 1'b0);
        check("ignored_hi", hi, 32'd2);
        check("ignored_lo", lo, 32'd14);
        tick();
        check("no_extra_done", done, 0);
        check("no_extra_busy", busy, 0);

        run_op(OP_MULT, 32'd3, 32'hFFFFFFFC, -1, 1'b1);

`ifdef MULDIV_FAST_MUL_EN
        rop = OP_DIVU;
`else
        rop = OP_MULTU;
`endif
        op = rop; a = 32'h1234; b = 32'h5678; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        tick();
        check("midrst_no_done", done, 0);
        run_op(OP_DIVU, 32'd9, 32'd3, -1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'b0;
                1: y = 32'hFFFFFFFF;
                2: y = $urandom_range(1, 16);
                default: y = $urandom;
            endcase
            run_op(2'($urandom), x, y, -1, 1'b0);
        end
        tick();
        check("final_done_low", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers. Sits directly downstream of the register file: its operands are the two register read ports (rs on `a`, rt on `b`). It executes MULT/MULTU/DIV/DIVU iteratively and holds the results in HI/LO for MFHI/MFLO. The control unit uses `busy` to stall any instruction that touches HI/LO or issues a new mul/div.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is verified.
- `clk` input 1: clock; all state changes on the posedge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a new operation. Accepted only when `busy`=0.
- `op` input 2: operation code. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input 32: operand 1, from register file read data 1. Dividend for divides.
- `b` input 32: operand 2, from register file read data 2. Divisor for divides.
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wd` input 32: MTHI/MTLO write data.
- `busy` output 1: an operation is in flight.
- `done` output 1: one-cycle pulse; HI/LO hold a new result.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC on an accepted `start`.
  - CALC → FIX after 32 iterations.
  - FIX → IDLE unconditionally.
- On accept, the unit latches `op`, `a` and `b`. Later changes on the inputs have no effect on the operation.
- Signed ops (MULT, DIV) convert operands to magnitudes at accept. The result sign is applied in FIX.
- Multiply: shift-add, one partial product per CALC cycle, 64-bit accumulator. FIX writes HI = product[63:32], LO = product[31:0].
- Divide: restoring, one quotient bit per CALC cycle. FIX writes LO = quotient, HI = remainder.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Divide by zero, signed or unsigned: LO = 32'hFFFFFFFF, HI = a. It takes the normal latency.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- `start` while `busy`=1 is ignored; the in-flight operation is not disturbed.
- `hi_we`/`lo_we` while `busy`=1 are ignored. Control must stall MTHI/MTLO.
- `hi_we`/`lo_we` in IDLE write `wd` at the edge.
  - If `start` is accepted at the same edge, the write also takes effect.
  - The operation result later overwrites it.
- `hi_we` and `lo_we` together write `wd` to both registers.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, datapath registers 0.
- Reset mid-operation: at the next edge the unit returns to IDLE with all outputs at reset values. The partial result is discarded and no `done` is produced.
- `start` is sampled at edge E0. `busy`=1 from after E0 until after E33.
- CALC occupies E1..E32. FIX is at E33.
  - At E33, HI/LO are written, `done`=1 and `busy`=0.
  - `done` is high for exactly the cycle after E33.
- A new `start` may be accepted at E34, the cycle `done` is high. Back-to-back throughput is one op per 34 cycles.
- `hi`/`lo` are registered. They are stable except at reset, FIX, or an IDLE MTHI/MTLO write.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU compute a full 64-bit product in one cycle and go IDLE → FIX directly.
  - `start` at E0 leads to a FIX write at E1; `done` is high in the cycle after E1.
  - Divides are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: all ops take the iterative 34-cycle path. No hardware multiplier is inferred.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - the FSM state enum;
  - the iteration count constant (32).
- Sub-module `muldiv_div_step` is combinational. It implements one restoring-divide step: partial remainder and divisor in; next remainder and quotient bit out.
- The top level holds the FSM, the iteration counter, operand/accumulator registers, sign fixup, and the HI/LO registers.

## Test plan
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=32'h00000001. `done` is in the 34th cycle after `start`; with `MULDIV_FAST_MUL_EN`, in the 2nd.
- MULT a=32'hFFFFFFFD (-3), b=5 → HI=32'hFFFFFFFF, LO=32'hFFFFFFF1 (-15).
- DIV a=-7, b=2 → LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- Corner cases:
  - DIV 32'h80000000 / 32'hFFFFFFFF → LO=32'h80000000, HI=0.
  - DIVU 32'h123 / 0 → LO=32'hFFFFFFFF, HI=32'h123.
- During DIVU 100/7:
  - pulse `start` (op MULTU, a=b=2) at busy cycle 10 → ignored, no extra `done`;
  - pulse `hi_we` with `wd`=32'hDEAD → ignored;
  - final result HI=2, LO=14.
- `rst` asserted in busy cycle 15 of a MULTU → next cycle `busy`=0, `hi`=`lo`=0, no `done`. A following DIVU 9/3 then gives LO=3, HI=0.
